// File: rtl/data_bus_router.sv
// -----------------------------------------------------------------------------
// data_bus_router
//
// Routes the core's OBI-style data port to the data memory window or to the
// peripheral window. Accesses that hit neither window are answered locally
// with an error response one cycle after grant. Outstanding transactions
// are tracked so that responses return to the core strictly in issue order.
// A change of target stalls until every outstanding transaction has drained.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_i/gnt_o/rvalid_o           core request, grant, response valid
//   addr_i, we_i, be_i, wdata_i    core request fields
//   rdata_o, err_o                 core response (zero when rvalid_o is low)
//   mem_*                          memory-window request/response
//   per_*                          peripheral-window request/response
//   protocol_err_o                 sticky: a downstream rvalid arrived that
//                                  no outstanding transaction was waiting for
// -----------------------------------------------------------------------------
module data_bus_router #(
   parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
   parameter logic [31:0] MEM_SIZE        = 32'h0000_2000,
   parameter logic [31:0] PERIPH_BASE     = 32'h8000_0000,
   parameter logic [31:0] PERIPH_SIZE     = 32'h0000_1000,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   // core port
   input  logic        req_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        err_o,
   // memory window
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   // peripheral window
   output logic        per_req_o,
   input  logic        per_gnt_i,
   input  logic        per_rvalid_i,
   output logic [31:0] per_addr_o,
   output logic        per_we_o,
   output logic [3:0]  per_be_o,
   output logic [31:0] per_wdata_o,
   input  logic [31:0] per_rdata_i,
   input  logic        per_err_i,
   // status
   output logic        protocol_err_o
);

   typedef enum logic [1:0] {
      TGT_NONE,
      TGT_MEM,
      TGT_PER,
      TGT_ERR
   } tgt_e;

   localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

   tgt_e        sel;
   tgt_e        cur_tgt_q, cur_tgt_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        err_pend_q;
   logic        protocol_err_q;
   logic        allowed;
   logic        accept;
   logic        unexpected;
   logic [31:0] mem_off, per_off;

   // Unsigned offsets: an address below a base wraps to a huge value and misses.
   assign mem_off = addr_i - MEM_BASE;
   assign per_off = addr_i - PERIPH_BASE;

   // Request fields are copied straight through; only req is gated.
   assign mem_addr_o  = addr_i;
   assign mem_we_o    = we_i;
   assign mem_be_o    = be_i;
   assign mem_wdata_o = wdata_i;
   assign per_addr_o  = addr_i;
   assign per_we_o    = we_i;
   assign per_be_o    = be_i;
   assign per_wdata_o = wdata_i;

   assign protocol_err_o = protocol_err_q;

   // NOTE: every signal driven here gets a default first, so no path through
   // the block leaves one unassigned and no latch is inferred.
   always_comb begin
      sel = TGT_ERR;
      if (mem_off < MEM_SIZE) begin
         sel = TGT_MEM;
      end else if (per_off < PERIPH_SIZE) begin
         sel = TGT_PER;
      end
   end

   // Request side: a new target is only accepted once the pipe is empty.
   always_comb begin
      allowed   = (cnt_q < MAX_CNT) && ((cnt_q == 3'd0) || (sel == cur_tgt_q));
      mem_req_o = req_i && allowed && (sel == TGT_MEM);
      per_req_o = req_i && allowed && (sel == TGT_PER);
      gnt_o     = 1'b0;
      case (sel)
         TGT_MEM: gnt_o = req_i && allowed && mem_gnt_i;
         TGT_PER: gnt_o = req_i && allowed && per_gnt_i;
         default: gnt_o = req_i && allowed;
      endcase
      accept = gnt_o;
   end

   // Response side: only the current target may answer; anything else is dropped.
   always_comb begin
      rvalid_o = 1'b0;
      rdata_o  = 32'h0;
      err_o    = 1'b0;
      case (cur_tgt_q)
         TGT_MEM: begin
            rvalid_o = mem_rvalid_i;
            rdata_o  = mem_rvalid_i ? mem_rdata_i : 32'h0;
            err_o    = mem_rvalid_i && mem_err_i;
         end
         TGT_PER: begin
            rvalid_o = per_rvalid_i;
            rdata_o  = per_rvalid_i ? per_rdata_i : 32'h0;
            err_o    = per_rvalid_i && per_err_i;
         end
         TGT_ERR: begin
            rvalid_o = err_pend_q;
            err_o    = err_pend_q;
         end
         default: ;
      endcase
      // cur_tgt is NONE exactly when nothing is outstanding, so this also
      // covers a response arriving while idle.
      unexpected = (mem_rvalid_i && (cur_tgt_q != TGT_MEM))
                || (per_rvalid_i && (cur_tgt_q != TGT_PER));
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({accept, rvalid_o})
         2'b10:   cnt_d = cnt_q + 3'd1;
         2'b01:   cnt_d = cnt_q - 3'd1;
         default: ;
      endcase
      cur_tgt_d = cur_tgt_q;
      if (accept) begin
         cur_tgt_d = sel;
      end else if (cnt_d == 3'd0) begin
         cur_tgt_d = TGT_NONE;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q          <= 3'd0;
         cur_tgt_q      <= TGT_NONE;
         err_pend_q     <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         cur_tgt_q  <= cur_tgt_d;
         // Each ERR accept is answered the very next cycle, so one bit suffices
         // even when ERR accesses are accepted back-to-back.
         err_pend_q <= accept && (sel == TGT_ERR);
         if (unexpected) begin
            protocol_err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_data_bus_router.sv
// -----------------------------------------------------------------------------
// tb_data_bus_router
//
// Self-checking bench for data_bus_router. The bench plays the core and both
// downstream slaves (queue-based, configurable latency and grant behaviour).
// A reference model keeps the list of outstanding transactions in issue order
// and predicts grant, downstream requests and every response from it.
// -----------------------------------------------------------------------------
module tb_data_bus_router;

   localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
   localparam logic [31:0] MEM_SIZE    = 32'h0000_2000;
   localparam logic [31:0] PERIPH_BASE = 32'h8000_0000;
   localparam logic [31:0] PERIPH_SIZE = 32'h0000_1000;
   localparam int          MAX_OUT     = 2;

   localparam int T_MEM = 1;
   localparam int T_PER = 2;
   localparam int T_ERR = 3;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_i, we_i;
   logic [31:0] addr_i, wdata_i;
   logic [3:0]  be_i;
   logic        gnt_o, rvalid_o, err_o, protocol_err_o;
   logic [31:0] rdata_o;
   logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_be_o;
   logic        per_req_o, per_gnt_i, per_rvalid_i, per_we_o, per_err_i;
   logic [31:0] per_addr_o, per_wdata_o, per_rdata_i;
   logic [3:0]  per_be_o;

   data_bus_router #(
      .MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE),
      .PERIPH_BASE(PERIPH_BASE), .PERIPH_SIZE(PERIPH_SIZE),
      .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_i(req_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
      .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
      .rdata_o(rdata_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .per_req_o(per_req_o), .per_gnt_i(per_gnt_i), .per_rvalid_i(per_rvalid_i),
      .per_addr_o(per_addr_o), .per_we_o(per_we_o), .per_be_o(per_be_o),
      .per_wdata_o(per_wdata_o), .per_rdata_i(per_rdata_i), .per_err_i(per_err_i),
      .protocol_err_o(protocol_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } resp_t;

   typedef struct {
      int          tgt;
      int          cyc;
      logic [31:0] data;
      logic        err;
   } exp_t;

   resp_t mem_q[$];
   resp_t per_q[$];
   exp_t  exp_q[$];

   logic [31:0] mem_arr[2048];
   logic [31:0] per_arr[1024];
   logic [31:0] ref_mem[2048];
   logic [31:0] ref_per[1024];
   logic [31:0] edges[8];

   int   cyc;
   int   n_assert;
   int   n_fail;
   logic prot_model;
   bit   inj_per, rand_gnt, rand_lat;
   bit   mem_gnt_en, per_gnt_en;
   int   mem_lat, per_lat;

   // values seen at the last sampling point
   logic        last_gnt, last_rvalid, last_err;
   logic [31:0] last_rdata;
   logic [3:0]  last_per_be;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int decode(input logic [31:0] a);
      if ((a - MEM_BASE) < MEM_SIZE) return T_MEM;
      if ((a - PERIPH_BASE) < PERIPH_SIZE) return T_PER;
      return T_ERR;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic bit per_err_region(input logic [31:0] a);
      logic [31:0] off;
      off = a - PERIPH_BASE;
      return off >= 32'hF00;
   endfunction

   // One clock cycle: drive slave-side inputs, sample and check at the falling
   // edge, then advance model and slaves. Entered and left at posedge + 1.
   task automatic tick();
      logic        mem_rv, per_rv, allowed, e_gnt, e_rv, e_err, unexpected;
      logic [31:0] e_rdata;
      int          sel, head, n, idx, lat;
      exp_t        e;
      resp_t       r;

      mem_gnt_i = rand_gnt ? ($urandom_range(0, 3) != 0) : mem_gnt_en;
      per_gnt_i = rand_gnt ? ($urandom_range(0, 3) != 0) : per_gnt_en;
      mem_rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      per_rv = (per_q.size() > 0) && (per_q[0].due <= cyc);
      mem_rvalid_i = mem_rv;
      mem_rdata_i  = mem_rv ? mem_q[0].data : $urandom;
      mem_err_i    = mem_rv ? mem_q[0].err : 1'($urandom_range(0, 1));
      per_rvalid_i = per_rv || inj_per;
      per_rdata_i  = per_rv ? per_q[0].data : $urandom;
      per_err_i    = per_rv ? per_q[0].err : 1'($urandom_range(0, 1));

      @(negedge clk_i);

      sel     = decode(addr_i);
      n       = exp_q.size();
      head    = (n > 0) ? exp_q[0].tgt : 0;
      allowed = req_i && (n < MAX_OUT) && ((n == 0) || (head == sel));
      e_gnt   = allowed && ((sel == T_MEM) ? mem_gnt_i : (sel == T_PER) ? per_gnt_i : 1'b1);
      e_rv    = ((head == T_MEM) && mem_rv) || ((head == T_PER) && per_rv)
             || ((head == T_ERR) && (exp_q[0].cyc == cyc - 1));
      e_rdata = e_rv ? exp_q[0].data : 32'h0;
      e_err   = e_rv ? exp_q[0].err : 1'b0;

      check("gnt", gnt_o, e_gnt);
      check("mem_req", mem_req_o, allowed && (sel == T_MEM));
      check("per_req", per_req_o, allowed && (sel == T_PER));
      check("rvalid", rvalid_o, e_rv);
      check("rdata", rdata_o, e_rdata);
      check("err", err_o, e_err);
      check("protocol_err", protocol_err_o, prot_model);
      check("mem_fields", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
            {addr_i, we_i, be_i, wdata_i});
      check("per_fields", {per_addr_o, per_we_o, per_be_o, per_wdata_o},
            {addr_i, we_i, be_i, wdata_i});

      last_gnt    = gnt_o;
      last_rvalid = rvalid_o;
      last_rdata  = rdata_o;
      last_err    = err_o;
      last_per_be = per_be_o;

      // reference model
      unexpected = (mem_rvalid_i && (head != T_MEM)) || (per_rvalid_i && (head != T_PER));
      if (unexpected) prot_model = 1'b1;
      if (e_rv) void'(exp_q.pop_front());
      if (e_gnt) begin
         e.tgt  = sel;
         e.cyc  = cyc;
         e.data = 32'h0;
         e.err  = 1'b0;
         if (sel == T_MEM) begin
            idx = int'((addr_i - MEM_BASE) >> 2);
            if (we_i) ref_mem[idx] = merge(ref_mem[idx], wdata_i, be_i);
            else      e.data = ref_mem[idx];
         end else if (sel == T_PER) begin
            idx = int'((addr_i - PERIPH_BASE) >> 2);
            if (per_err_region(addr_i)) e.err = 1'b1;
            else if (we_i) ref_per[idx] = merge(ref_per[idx], wdata_i, be_i);
            else e.data = ref_per[idx];
         end else begin
            e.err = 1'b1;
         end
         exp_q.push_back(e);
      end

      // downstream slaves react to what the router actually drove
      if (mem_rv) void'(mem_q.pop_front());
      if (per_rv) void'(per_q.pop_front());
      if (mem_req_o && mem_gnt_i) begin
         lat    = rand_lat ? $urandom_range(1, 4) : mem_lat;
         idx    = int'(mem_addr_o[12:2]);
         r.due  = cyc + lat;
         r.err  = 1'b0;
         r.data = mem_we_o ? 32'h0 : mem_arr[idx];
         if (mem_we_o) mem_arr[idx] = merge(mem_arr[idx], mem_wdata_o, mem_be_o);
         mem_q.push_back(r);
      end
      if (per_req_o && per_gnt_i) begin
         lat    = rand_lat ? $urandom_range(1, 4) : per_lat;
         idx    = int'(per_addr_o[11:2]);
         r.due  = cyc + lat;
         r.err  = per_err_region(per_addr_o);
         r.data = 32'h0;
         if (!r.err) begin
            if (per_we_o) per_arr[idx] = merge(per_arr[idx], per_wdata_o, per_be_o);
            else          r.data = per_arr[idx];
         end
         per_q.push_back(r);
      end

      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   // Hold a request until granted; waited = cycles spent without grant.
   task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output int waited);
      bit granted;
      granted = 1'b0;
      waited  = 0;
      req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = d;
      for (int k = 0; k < 60 && !granted; k++) begin
         tick();
         if (last_gnt) granted = 1'b1;
         else waited++;
      end
      check("issue_timeout", granted, 1'b1);
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic idle(input int cycles);
      req_i = 1'b0;
      repeat (cycles) tick();
   endtask

   task automatic drain();
      req_i = 1'b0;
      for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick();
      check("drain", exp_q.size(), 0);
   endtask

   // Reset asserted between edges while a stale memory response is on the bus.
   task automatic do_reset();
      req_i        = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0_BAD0;
      rst_ni       = 1'b0;
      #1;
      check("rst_rvalid", rvalid_o, 1'b0);
      check("rst_err", err_o, 1'b0);
      check("rst_rdata", rdata_o, 32'h0);
      check("rst_protocol_err", protocol_err_o, 1'b0);
      check("rst_reqs", {gnt_o, mem_req_o, per_req_o}, 3'b000);
      mem_q.delete(); per_q.delete(); exp_q.delete();
      prot_model   = 1'b0;
      mem_rvalid_i = 1'b0;
      per_rvalid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      cyc += 2;
   endtask

   initial begin
      int          w;
      logic [31:0] a;

      n_assert = 0; n_fail = 0; cyc = 0;
      prot_model = 1'b0; inj_per = 1'b0; rand_gnt = 1'b0; rand_lat = 1'b0;
      mem_gnt_en = 1'b1; per_gnt_en = 1'b1; mem_lat = 1; per_lat = 1;
      req_i = 1'b0; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0; wdata_i = 32'h0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
      per_gnt_i = 1'b0; per_rvalid_i = 1'b0; per_rdata_i = 32'h0; per_err_i = 1'b0;
      edges = '{32'h0000_1FFC, 32'h0000_1FFF, 32'h0000_2000, 32'h7FFF_FFFC,
                32'h8000_0000, 32'h8000_0FFF, 32'h8000_1000, 32'hFFFF_FFFC};
      for (int i = 0; i < 2048; i++) begin
         mem_arr[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
         ref_mem[i] = mem_arr[i];
      end
      for (int i = 0; i < 1024; i++) begin
         per_arr[i] = (i * 32'h0001_0003) ^ 32'h5A00_005A;
         ref_per[i] = per_arr[i];
      end
      mem_arr[4] = 32'hDEAD_BEEF;
      ref_mem[4] = 32'hDEAD_BEEF;

      // power-on reset
      rst_ni = 1'b0;
      #2;
      check("por_rvalid", rvalid_o, 1'b0);
      check("por_rdata_err", {rdata_o, err_o}, 33'h0);
      check("por_protocol_err", protocol_err_o, 1'b0);
      check("por_reqs", {gnt_o, mem_req_o, per_req_o}, 3'b000);
      @(posedge clk_i); @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      idle(2);

      // memory read, one-cycle latency
      issue(32'h0000_0010, 1'b0, 4'hF, 32'h0, w);
      check("mem_read_wait", w, 0);
      idle(1);
      check("mem_read_rvalid", last_rvalid, 1'b1);
      check("mem_read_rdata", last_rdata, 32'hDEAD_BEEF);
      check("mem_read_err", last_err, 1'b0);
      idle(2);

      // peripheral write with the grant withheld for three cycles
      per_gnt_en = 1'b0;
      req_i = 1'b1; addr_i = 32'h8000_0004; we_i = 1'b1; be_i = 4'b0011;
      wdata_i = 32'hCAFE_1234;
      repeat (3) begin
         tick();
         check("per_stall_gnt", last_gnt, 1'b0);
         check("per_be", last_per_be, 4'b0011);
      end
      per_gnt_en = 1'b1;
      issue(32'h8000_0004, 1'b1, 4'b0011, 32'hCAFE_1234, w);
      check("per_wait_after_gnt", w, 0);
      drain();
      issue(32'h8000_0004, 1'b0, 4'hF, 32'h0, w);
      drain();

      // unmapped read: local error response
      issue(32'h4000_0000, 1'b0, 4'hF, 32'h0, w);
      check("err_wait", w, 0);
      idle(1);
      check("err_rvalid", last_rvalid, 1'b1);
      check("err_err", last_err, 1'b1);
      check("err_rdata", last_rdata, 32'h0);
      idle(1);

      // two memory reads then a peripheral read: target change stalls
      per_lat = 3;
      issue(32'h0000_0010, 1'b0, 4'hF, 32'h0, w);
      issue(32'h0000_0020, 1'b0, 4'hF, 32'h0, w);
      check("mem2_wait", w, 0);
      issue(32'h8000_0008, 1'b0, 4'hF, 32'h0, w);
      check("per_after_mem_wait", w, 1);
      drain();
      per_lat = 1;

      // stray peripheral response while idle
      inj_per = 1'b1;
      idle(1);
      check("stray_rvalid", last_rvalid, 1'b0);
      inj_per = 1'b0;
      idle(4);
      check("stray_sticky", protocol_err_o, 1'b1);
      do_reset();
      idle(1);

      // reset with two memory reads outstanding
      mem_lat = 4;
      issue(32'h0000_0040, 1'b0, 4'hF, 32'h0, w);
      issue(32'h0000_0044, 1'b0, 4'hF, 32'h0, w);
      check("two_outstanding", exp_q.size(), 2);
      do_reset();
      mem_lat = 1;
      issue(32'h8000_0010, 1'b0, 4'hF, 32'h0, w);
      check("per_after_reset_wait", w, 0);
      drain();

      // randomized traffic with random grants and latencies
      rand_gnt = 1'b1;
      rand_lat = 1'b1;
      for (int t = 0; t < 300; t++) begin
         case ($urandom_range(0, 5))
            0:       a = {19'h0, 13'($urandom)};
            1:       a = PERIPH_BASE | {20'h0, 12'($urandom)};
            2:       a = edges[$urandom_range(0, 7)];
            3:       a = $urandom;
            default: a = {26'h0, 6'($urandom)};
         endcase
         issue(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, w);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();
      check("final_protocol_err", protocol_err_o, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/data_bus_router.md
# data_bus_router

Routes the core's OBI-style data port to two downstream targets: the data memory window and a memory-mapped peripheral window (the AES coprocessor register file). Unmapped accesses are answered locally with an error response. The block sits between the core data port and the data memory / peripheral slaves. It tracks outstanding transactions so that read data and errors return to the core strictly in issue order.

## Interface
- MEM_BASE, 32'h0000_0000, byte base address of the memory window
- MEM_SIZE, 32'h0000_2000, memory window size in bytes (power of two, aligned to MEM_BASE)
- PERIPH_BASE, 32'h8000_0000, byte base address of the peripheral window
- PERIPH_SIZE, 32'h0000_1000, peripheral window size in bytes (power of two, aligned)
- MAX_OUTSTANDING, 2, maximum number of granted but unanswered transactions (1..7)

Ports (clock and reset are already decided):
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i / gnt_o / rvalid_o  in/out/out  1  core request, grant and response valid
- addr_i  in  32  core byte address; bits [1:0] are passed through and ignored for decode
- we_i, be_i, wdata_i  in  1/4/32  core write enable, byte enables, write data
- rdata_o, err_o  out  32/1  core response data and error
- mem_req_o, mem_gnt_i, mem_rvalid_i  out/in/in  1  memory handshake
- mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  out  32/1/4/32  memory request fields (copies of the core fields)
- mem_rdata_i, mem_err_i  in  32/1  memory response
- per_req_o, per_gnt_i, per_rvalid_i, per_addr_o, per_we_o, per_be_o, per_wdata_o, per_rdata_i, per_err_i: the same set for the peripheral
- protocol_err_o  out  1  sticky flag, set on an unexpected downstream rvalid

## Operation
- Decode: sel = MEM if (addr_i - MEM_BASE) < MEM_SIZE, PER if (addr_i - PERIPH_BASE) < PERIPH_SIZE, otherwise ERR. Subtraction is unsigned 32-bit, so addresses below a base wrap and miss.
- State:
  - cnt: 0..MAX_OUTSTANDING.
  - cur_tgt: one of NONE, MEM, PER, ERR. cur_tgt is NONE exactly when cnt == 0.
- allowed = (cnt < MAX_OUTSTANDING) && (cnt == 0 || sel == cur_tgt).
  - A change of target stalls until all outstanding transactions have drained. This guarantees in-order responses.
- Request forwarding:
  - mem_req_o = req_i && allowed && sel==MEM.
  - per_req_o = req_i && allowed && sel==PER.
  - Request fields are always driven from the core fields.
- gnt_o = req_i && allowed && (sel==MEM ? mem_gnt_i : sel==PER ? per_gnt_i : 1).
- On accept (req_i && gnt_o): cur_tgt <= sel.
- ERR target:
  - An accepted ERR request sets err_pend.
  - The next cycle produces rvalid_o=1, err_o=1, rdata_o=0.
  - Writes to unmapped space are discarded.
- Response mux:
  - cur_tgt MEM: rvalid_o = mem_rvalid_i, with rdata/err taken from mem.
  - cur_tgt PER: the same, from per.
  - cur_tgt ERR: rvalid_o = err_pend.
  - rdata_o = 0 and err_o = 0 whenever rvalid_o = 0.
- cnt update: +1 on accept, -1 on rvalid_o, unchanged when both happen in the same cycle.
- When cnt reaches 0 with no accept in that cycle, cur_tgt <= NONE.
- Unexpected rvalid (any rvalid_i from a target that is not cur_tgt, or while cnt == 0):
  - the response is dropped (not forwarded);
  - protocol_err_o <= 1, cleared only by reset.

## Timing
- Reset values:
  - rvalid_o=0, err_o=0, rdata_o=0, protocol_err_o=0;
  - cnt=0, cur_tgt=NONE, err_pend=0.
  - Request outputs are 0 because req_i gating applies.
- gnt_o, mem_req_o and per_req_o are combinational from req_i, addr_i, the downstream gnt and state. No registered request path is used.
- Response path: rvalid_o/rdata_o/err_o are combinational from the selected target, adding zero latency. Memory read latency therefore remains 1 cycle after grant. ERR latency is 1 cycle after grant.
- Back-to-back accesses to the same target are accepted every cycle while cnt < MAX_OUTSTANDING. Accept and response in the same cycle keep throughput at 1/cycle.
- At cnt == MAX_OUTSTANDING: gnt_o=0 and the downstream req is 0. The core must hold the request stable until it is granted.
- Reset asserted mid-transaction:
  - all state clears immediately and in-flight responses are lost.
  - Downstream slaves share rst_ni, so no late responses are expected.

## Test plan
- Read MEM 0x0000_0010 (memory preloaded with 0xDEAD_BEEF) -> gnt same cycle; rvalid_o next cycle with rdata_o=0xDEAD_BEEF, err_o=0.
- Write PER 0x8000_0004 with be=4'b0011 while per_gnt_i is held low 3 cycles -> gnt_o low 3 cycles; per_be_o=4'b0011; one rvalid_o with err_o=0 after the peripheral responds.
- Read 0x4000_0000 (unmapped) -> gnt same cycle; next cycle rvalid_o=1, err_o=1, rdata_o=0; neither downstream req asserts.
- Two MEM reads, then a PER read issued back-to-back with a 3-cycle peripheral latency -> PER req is stalled until both MEM rvalids have returned; the three responses return in order; cnt never exceeds 2.
- Inject per_rvalid_i while cnt==0 -> rvalid_o stays 0; protocol_err_o rises next cycle and stays 1 until rst_ni is pulsed.
- Assert rst_ni low with 2 MEM reads outstanding -> all outputs go to their reset values immediately; after release, a PER request is granted without stall.
